// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: single-word read/write FSM with
// configurable read wait and write-pulse width, registered SRAM strobes.
module sram_ctrl #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WAIT_RD = 1,
  parameter int unsigned WAIT_WR = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [31:0]         addr_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] sel_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                ack_o,
  output logic                busy_o,
  inout  wire  [DATA_W-1:0]   ram_data,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_be_n,
  output logic                ram_ce_n,
  output logic                ram_oe_n,
  output logic                ram_we_n
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   wdata;
  logic                drive;
  logic [DATA_W-1:0]   rd_masked;

  // Byte offset and address bits above the SRAM range are intentionally dropped.
  wire unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  // Write data is on the bus only from WR_SETUP through WR_HOLD.
  assign ram_data = drive ? wdata : {DATA_W{1'bz}};

  // Read data with unselected byte lanes forced to zero.
  always_comb begin
    rd_masked = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (!ram_be_n[i]) rd_masked[8*i +: 8] = ram_data[8*i +: 8];
    end
  end

  // Access FSM; strobes are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wdata    <= '0;
      drive    <= 1'b0;
      data_o   <= '0;
      ack_o    <= 1'b0;
      busy_o   <= 1'b0;
      ram_addr <= '0;
      ram_be_n <= '1;
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
    end else begin
      ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_i) begin
            ram_addr <= addr_i[ADDR_W+1:2];
            ram_be_n <= ~sel_i;
            wdata    <= data_i;
            busy_o   <= 1'b1;
            ram_ce_n <= 1'b0;
            if (we_i) begin
              state <= WR_SETUP;
              drive <= 1'b1;
            end else begin
              state    <= RD;
              ram_oe_n <= 1'b0;
              cnt      <= CNT_W'(WAIT_RD);
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            data_o   <= rd_masked;
            ack_o    <= 1'b1;
            busy_o   <= 1'b0;
            state    <= IDLE;
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_be_n <= '1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_SETUP: begin
          state    <= WR_PULSE;
          cnt      <= CNT_W'(WAIT_WR);
          // With no byte selected the strobe never asserts, timing is unchanged.
          ram_we_n <= &ram_be_n;
        end
        WR_PULSE: begin
          if (cnt == '0) begin
            state    <= WR_HOLD;
            ram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_HOLD: begin
          ack_o    <= 1'b1;
          busy_o   <= 1'b0;
          state    <= IDLE;
          drive    <= 1'b0;
          ram_ce_n <= 1'b1;
          ram_be_n <= '1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default-timing and slow-timing instances,
// each attached to a pair of 16-bit byte-maskable SRAM models.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [3:0]  sel = '0;

  logic [31:0] d0, d1;
  logic        ack0, ack1, busy0, busy1;
  wire  [31:0] bus0, bus1;
  logic [19:0] ra0, ra1;
  logic [3:0]  be0, be1;
  logic        ce0, ce1, oe0, oe1, we0, we1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_ctrl u_dut (
    .clk(clk), .rst(rst), .req_i(req0), .we_i(we), .addr_i(addr),
    .data_i(wd), .sel_i(sel), .data_o(d0), .ack_o(ack0), .busy_o(busy0),
    .ram_data(bus0), .ram_addr(ra0), .ram_be_n(be0),
    .ram_ce_n(ce0), .ram_oe_n(oe0), .ram_we_n(we0)
  );

  sram_ctrl #(.WAIT_RD(3), .WAIT_WR(2)) u_slow (
    .clk(clk), .rst(rst), .req_i(req1), .we_i(we), .addr_i(addr),
    .data_i(wd), .sel_i(sel), .data_o(d1), .ack_o(ack1), .busy_o(busy1),
    .ram_data(bus1), .ram_addr(ra1), .ram_be_n(be1),
    .ram_ce_n(ce1), .ram_oe_n(oe1), .ram_we_n(we1)
  );

  // SRAM models: low and high 16-bit devices per controller.
  logic [15:0] m0_lo [0:4095];
  logic [15:0] m0_hi [0:4095];
  logic [15:0] m1_lo [0:4095];
  logic [15:0] m1_hi [0:4095];

  assign bus0[15:0]  = (!ce0 && !oe0 && we0) ? m0_lo[ra0[11:0]] : 16'hzzzz;
  assign bus0[31:16] = (!ce0 && !oe0 && we0) ? m0_hi[ra0[11:0]] : 16'hzzzz;
  assign bus1[15:0]  = (!ce1 && !oe1 && we1) ? m1_lo[ra1[11:0]] : 16'hzzzz;
  assign bus1[31:16] = (!ce1 && !oe1 && we1) ? m1_hi[ra1[11:0]] : 16'hzzzz;

  // Byte-masked write while chip select and write strobe are both low.
  always @(posedge clk) begin
    if (!ce0 && !we0) begin
      if (!be0[0]) m0_lo[ra0[11:0]][7:0]  <= bus0[7:0];
      if (!be0[1]) m0_lo[ra0[11:0]][15:8] <= bus0[15:8];
      if (!be0[2]) m0_hi[ra0[11:0]][7:0]  <= bus0[23:16];
      if (!be0[3]) m0_hi[ra0[11:0]][15:8] <= bus0[31:24];
    end
    if (!ce1 && !we1) begin
      if (!be1[0]) m1_lo[ra1[11:0]][7:0]  <= bus1[7:0];
      if (!be1[1]) m1_lo[ra1[11:0]][15:8] <= bus1[15:8];
      if (!be1[2]) m1_hi[ra1[11:0]][7:0]  <= bus1[23:16];
      if (!be1[3]) m1_hi[ra1[11:0]][15:8] <= bus1[31:24];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One transaction starting at a falling edge (cycle 0). Request inputs are
  // scrambled while busy to show they are ignored. Returns at the falling edge
  // of the ack cycle; lat=-1 if no ack within the budget.
  task automatic access(input int inst, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int lat, output logic [31:0] rdat,
                        output int we_low, output int bad);
    logic [31:0] exp_bus;
    we = w; addr = a; wd = d; sel = s;
    if (inst == 0) req0 = 1'b1; else req1 = 1'b1;
    lat = -1; we_low = 0; bad = 0; rdat = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin we = ~w; addr = a ^ 32'h30; wd = ~d; sel = ~s; end
      if (c == 2) begin req0 = 1'b0; req1 = 1'b0; end
      if ((inst == 0) ? !we0 : !we1) we_low++;
      exp_bus = (inst == 0) ? {m0_hi[ra0[11:0]], m0_lo[ra0[11:0]]}
                            : {m1_hi[ra1[11:0]], m1_lo[ra1[11:0]]};
      if ((inst == 0) ? !oe0 : !oe1) begin
        if (((inst == 0) ? bus0 : bus1) !== exp_bus) bad++;
      end
      if ((inst == 0) ? ack0 : ack1) begin
        lat = c;
        rdat = (inst == 0) ? d0 : d1;
        if ((inst == 0) ? busy0 : busy1) bad++;
        break;
      end else if (!((inst == 0) ? busy0 : busy1)) begin
        bad++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, wl, bad, acks;
    logic [31:0] r;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", d0, 32'h0);
    check("rst_ctrl", 32'({ack0, busy0, ce0, oe0, we0, be0}), 32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hf}));
    rst = 1'b1;
    @(negedge clk);

    // Four writes, then reverse read-back
    for (int i = 0; i < 4; i++) begin
      access(0, 1'b1, 32'(i * 4), 32'(i), 4'hf, lat, r, wl, bad);
      check("wr_lat", 32'(lat), 32'd5);
      check("wr_we_low", 32'(wl), 32'd2);
    end
    for (int i = 3; i >= 0; i--) begin
      access(0, 1'b0, 32'(i * 4), 32'h0, 4'hf, lat, r, wl, bad);
      check("rd_lat", 32'(lat), 32'd3);
      check("rd_data", r, 32'(i));
      check("rd_bus_busy", 32'(bad), 32'd0);
    end

    // Write then read in the ack cycle with no gap
    access(0, 1'b1, 32'h1000, 32'h2333, 4'hf, lat, r, wl, bad);
    check("b2b_wr_lat", 32'(lat), 32'd5);
    access(0, 1'b0, 32'h1000, 32'h0, 4'hf, lat, r, wl, bad);
    check("b2b_rd_lat", 32'(lat), 32'd3);
    check("b2b_rd_data", r, 32'h0000_2333);

    // Byte-select merging and read masking
    access(0, 1'b1, 32'h100, 32'hAABBCCDD, 4'b1111, lat, r, wl, bad);
    access(0, 1'b1, 32'h100, 32'h11223344, 4'b0101, lat, r, wl, bad);
    access(0, 1'b0, 32'h100, 32'h0, 4'b1111, lat, r, wl, bad);
    check("sel_merge", r, 32'hAA22CC44);
    access(0, 1'b0, 32'h100, 32'h0, 4'b0011, lat, r, wl, bad);
    check("sel_mask", r, 32'h0000CC44);

    // Write with no byte selected: full timing, no strobe, data_o held
    access(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, lat, r, wl, bad);
    check("nosel_lat", 32'(lat), 32'd5);
    check("nosel_we_low", 32'(wl), 32'd0);
    check("nosel_hold", d0, 32'h0000CC44);
    access(0, 1'b0, 32'h100, 32'h0, 4'b1111, lat, r, wl, bad);
    check("nosel_rd", r, 32'hAA22CC44);

    // Address aliasing above the SRAM range
    access(0, 1'b1, 32'h0040_0000, 32'hCAFEF00D, 4'hf, lat, r, wl, bad);
    access(0, 1'b0, 32'h0000_0000, 32'h0, 4'hf, lat, r, wl, bad);
    check("alias_rd", r, 32'hCAFEF00D);

    // Reset during the write pulse
    access(0, 1'b1, 32'h20, 32'h55, 4'hf, lat, r, wl, bad);
    we = 1'b1; addr = 32'h20; wd = 32'h66; sel = 4'hf; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    check("pulse_we", 32'(we0), 32'd0);
    check("pulse_bus", bus0, 32'h66);
    rst = 1'b0;
    @(negedge clk);
    check("abort_strobe", 32'({ce0, oe0, we0, be0}), 32'({1'b1, 1'b1, 1'b1, 4'hf}));
    check("abort_ack_busy", 32'({ack0, busy0}), 32'd0);
    check("abort_data", d0, 32'h0);
    we = 1'b0; req0 = 1'b1;
    @(negedge clk);
    check("rst_ignore_req", 32'({busy0, ce0}), 32'({1'b0, 1'b1}));
    req0 = 1'b0; rst = 1'b1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack0) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    access(0, 1'b0, 32'h20, 32'h0, 4'hf, lat, r, wl, bad);
    check("abort_old_or_new", 32'(r == 32'h55 || r == 32'h66), 32'd1);

    // Slow timing instance
    access(1, 1'b1, 32'h8, 32'h12345678, 4'hf, lat, r, wl, bad);
    check("slow_wr_lat", 32'(lat), 32'd6);
    check("slow_we_low", 32'(wl), 32'd3);
    access(1, 1'b0, 32'h8, 32'h0, 4'hf, lat, r, wl, bad);
    check("slow_rd_lat", 32'(lat), 32'd5);
    check("slow_rd_data", r, 32'h12345678);
    check("slow_rd_bus_busy", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
